// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and direction constants for the Gray counter family.
// The functions operate on 32-bit values; narrower callers zero-extend their operands.
package gray_pkg;
  localparam int MAX_W = 32;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs decode correctly: leading zeros stay zero.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray2bin_comb.sv
// Purely combinational Gray-to-binary decoder; also reusable for CDC pointer decode.
module gray2bin_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gry,
  output logic [WIDTH-1:0] bin
);
  assign bin[WIDTH-1] = gry[WIDTH-1];
  for (genvar i = WIDTH-2; i >= 0; i--) begin : g_xor
    assign bin[i] = bin[i+1] ^ gry[i];
  end
endmodule

// File: rtl/gray_counter.sv
// Registered up/down counter with binary/Gray parallel load. Binary and Gray outputs are
// both flops, so the Gray value is glitch-free for CDC and position-tracking consumers.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gry_out,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt, cnt_nxt, ld_dec;
  logic             wrap_nxt;

  gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
    .gry (load_val),
    .bin (ld_dec)
  );

  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (load) begin
      cnt_nxt = load_gray ? ld_dec : load_val;
    end else if (en) begin
      if (up == DIR_UP) begin
        cnt_nxt  = cnt + ONE;
        wrap_nxt = &cnt;
      end else begin
        cnt_nxt  = cnt - ONE;
        wrap_nxt = ~|cnt;
      end
    end
  end

  // Gray is encoded from the next-state value so it is registered alongside cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      gry_out <= '0;
      wrap    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      gry_out <= cnt_nxt ^ (cnt_nxt >> 1);
      wrap    <= wrap_nxt;
    end
  end

  assign bin_out = cnt;
endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter at WIDTH=4 and WIDTH=8 driven from shared controls.
module tb_gray_counter;
  typedef struct {
    logic [31:0] b;
    logic [31:0] g;
    logic        w;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, up, load, load_gray;
  logic [3:0] lv4;
  logic [7:0] lv8;
  logic [3:0] bin4, gry4;
  logic [7:0] bin8, gry8;
  logic       wrap4, wrap8;

  int   checks = 0;
  int   errors = 0;
  exp_t q4[$];
  exp_t q8[$];
  logic [31:0] m4 = 0, m8 = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .load_val(lv4), .bin_out(bin4), .gry_out(gry4), .wrap(wrap4)
  );

  gray_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .load_val(lv8), .bin_out(bin8), .gry_out(gry8), .wrap(wrap8)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Prefix-XOR decode, deliberately a different formulation from the RTL chain.
  function automatic logic [31:0] g2b(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

  function automatic exp_t model(inout logic [31:0] c, input int w, input logic r, e, u,
                                 l, lg, input logic [31:0] v);
    logic [31:0] m;
    exp_t x;
    m = (32'd1 << w) - 32'd1;
    x.w = 1'b0;
    if (r) c = 0;
    else if (l) c = lg ? (g2b(v & m) & m) : (v & m);
    else if (e) begin
      if (u) begin x.w = (c == m); c = (c + 1) & m; end
      else begin x.w = (c == 0); c = (c - 1) & m; end
    end
    x.b = c;
    x.g = c ^ (c >> 1);
    return x;
  endfunction

  exp_t got4, got8;

  task automatic step(input logic r, e, u, l, lg, input logic [7:0] v);
    exp_t e4, e8;
    rst = r; en = e; up = u; load = l; load_gray = lg; lv4 = v[3:0]; lv8 = v;
    q4.push_back(model(m4, 4, r, e, u, l, lg, {28'd0, v[3:0]}));
    q8.push_back(model(m8, 8, r, e, u, l, lg, {24'd0, v}));
    @(posedge clk); #1;
    e4 = q4.pop_front();
    e8 = q8.pop_front();
    chk("bin4", 32'(bin4), e4.b);
    chk("gry4", 32'(gry4), e4.g);
    chk("wrap4", 32'(wrap4), 32'(e4.w));
    chk("bin8", 32'(bin8), e8.b);
    chk("gry8", 32'(gry8), e8.g);
    chk("wrap8", 32'(wrap8), 32'(e8.w));
    got4.b = 32'(bin4); got4.g = 32'(gry4); got4.w = wrap4;
    got8.b = 32'(bin8); got8.g = 32'(gry8); got8.w = wrap8;
  endtask

  task automatic sweep(input int w, input logic dir);
    int n, wraps;
    logic [31:0] prev;
    n = (1 << w) + 2;
    wraps = 0;
    prev = (w == 4) ? got4.g : got8.g;
    for (int i = 0; i < n; i++) begin
      step(0, 1, dir, 0, 0, 8'h00);
      if (w == 4) begin
        chk("sw4_ham", 32'($countones(got4.g ^ prev)), 32'd1);
        chk("sw4_rel", got4.g, got4.b ^ (got4.b >> 1));
        prev = got4.g;
        wraps += int'(got4.w);
      end else begin
        chk("sw8_ham", 32'($countones(got8.g ^ prev)), 32'd1);
        chk("sw8_rel", got8.g, got8.b ^ (got8.b >> 1));
        prev = got8.g;
        wraps += int'(got8.w);
      end
    end
    chk(w == 4 ? "sw4_wraps" : "sw8_wraps", 32'(wraps), 32'd1);
  endtask

  initial begin
    rst = 1; en = 0; up = 1; load = 0; load_gray = 0; lv4 = 0; lv8 = 0;
    @(posedge clk); #1;
    step(1, 0, 1, 0, 0, 8'h00);
    chk("rst_bin", 32'(bin4), 32'd0);

    // Reset mid-count from 9, then reset dominating load and en.
    step(0, 0, 1, 1, 0, 8'h09);
    chk("ld9", 32'(bin4), 32'd9);
    step(1, 1, 1, 0, 0, 8'h00);
    chk("t1_bin", 32'(bin4), 32'd0);
    step(1, 1, 1, 0, 0, 8'h00);
    step(1, 1, 1, 1, 0, 8'h07);
    chk("t1_prio_bin", 32'(bin4), 32'd0);
    chk("t1_prio_gry", 32'(gry4), 32'd0);

    // Up-count wrap.
    step(0, 0, 1, 1, 0, 8'h0E);
    step(0, 1, 1, 0, 0, 8'h00);
    chk("t2_bin_f", 32'(bin4), 32'hF);
    chk("t2_gry_f", 32'(gry4), 32'h8);
    step(0, 1, 1, 0, 0, 8'h00);
    chk("t2_wrap", 32'(wrap4), 32'd1);
    chk("t2_bin_0", 32'(bin4), 32'h0);
    step(0, 1, 1, 0, 0, 8'h00);
    chk("t2_wrap_lo", 32'(wrap4), 32'd0);
    chk("t2_bin_1", 32'(bin4), 32'h1);

    // Down-count wrap.
    step(0, 0, 0, 1, 0, 8'h01);
    step(0, 1, 0, 0, 0, 8'h00);
    chk("t3_bin_0", 32'(bin4), 32'h0);
    chk("t3_wrap0", 32'(wrap4), 32'd0);
    step(0, 1, 0, 0, 0, 8'h00);
    chk("t3_bin_f", 32'(bin4), 32'hF);
    chk("t3_gry_f", 32'(gry4), 32'h8);
    chk("t3_wrap", 32'(wrap4), 32'd1);

    // Gray and binary load formats.
    step(0, 0, 1, 1, 1, 8'h0F);
    chk("t4_gbin", 32'(bin4), 32'hA);
    chk("t4_ggry", 32'(gry4), 32'hF);
    step(0, 0, 1, 1, 0, 8'h0C);
    chk("t4_bgry", 32'(gry4), 32'hA);

    // Load beats enable from max: no increment, no wrap.
    step(0, 0, 1, 1, 0, 8'h0F);
    step(0, 1, 1, 1, 0, 8'h05);
    chk("t5_bin", 32'(bin4), 32'h5);
    chk("t5_wrap", 32'(wrap4), 32'd0);

    // Hold, then direction toggling each cycle across 0/max.
    step(0, 0, 0, 0, 0, 8'h00);
    chk("hold", 32'(bin4), 32'h5);
    step(0, 0, 1, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, i[0] ? 1'b1 : 1'b0, 0, 0, 8'h00);

    step(1, 0, 1, 0, 0, 8'h00);
    sweep(4, 1'b1);
    sweep(4, 1'b0);
    step(1, 0, 1, 0, 0, 8'h00);
    sweep(8, 1'b1);
    sweep(8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised, registered up/down Gray-code counter with binary or Gray-coded parallel load. It is the sequential successor to the team's 4-bit combinational binary-to-Gray converter. Both the binary count and its Gray encoding are presented as registered outputs, so consumers such as clock-domain-crossing pointers and encoder position trackers read glitch-free Gray values. A single-cycle wrap pulse flags rollover in either direction.

## Interface
Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous and active-high
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  parallel load strobe
- load_gray  input  1  load format: 1 = load_val is Gray-coded, 0 = binary
- load_val  input  WIDTH  value to load
- bin_out  output  WIDTH  registered binary count
- gry_out  output  WIDTH  registered Gray encoding of bin_out
- wrap  output  1  one-cycle pulse on rollover

## Operation
- Internal state is one WIDTH-bit binary register `cnt`.
- gry_out always equals cnt ^ (cnt >> 1) in the same cycle. It is registered alongside cnt, not decoded after the flop.
- Per-edge priority is rst > load > en > hold.
- On rst: cnt=0, bin_out=0, gry_out=0, wrap=0.
- On load with load_gray=0: cnt ← load_val.
- On load with load_gray=1: cnt ← gray2bin(load_val), where b[W-1]=g[W-1] and b[i]=b[i+1]^g[i].
- Load forces wrap=0, regardless of en and up.
- On en with up=1: cnt ← cnt+1, modulo 2^WIDTH. wrap=1 only when cnt was 2^WIDTH−1.
- On en with up=0: cnt ← cnt−1, modulo 2^WIDTH. wrap=1 only when cnt was 0.
- On hold (en=0, load=0): cnt unchanged, wrap=0.
- Arithmetic is unsigned and truncated to WIDTH bits, with no saturation.
- Consecutive gry_out values during counting differ in exactly one bit, including across a wrap.
- No state machine beyond the counter register. Direction may change on any cycle, and the new direction takes effect on that edge.

## Timing
- All outputs are registered, with 1-cycle latency from the sampling edge.
- Inputs are sampled on the rising clk edge.
- Reset takes effect on the first edge at which rst=1. All outputs read 0 from that edge onward, including reset asserted mid-count or coincident with load or en.
- First count step: the first edge after rst deasserts with en=1.
- wrap is high for exactly one cycle per rollover. It re-asserts on every rollover during sustained counting, for example every 16 cycles at WIDTH=4.
- A load coincident with en=1 loads; no step is applied that cycle.
- With up toggling every cycle and en=1, the count alternates between two values. wrap fires only on the 0↔max transitions.
- No combinational path exists from any input to any output.

## Structure
- Shared package `gray_pkg` holds:
  - function bin2gray(WIDTH-generic, via a parameterised let/function)
  - function gray2bin
  - constant DIR_UP=1'b1 and constant DIR_DOWN=1'b0
- One sub-module is natural: `gray2bin_comb`, a parametrised purely combinational Gray→binary decoder (WIDTH param, in gry, out bin) on the load path. It is reusable elsewhere for CDC pointer decode.
- bin2gray stays inline, since it is a single XOR expression.
- The top level holds the cnt register, the next-state mux, the wrap logic and the output registers.

## Test plan
All scenarios use WIDTH=4 unless stated otherwise.
1. Reset: rst=1 for 2 cycles mid-count from cnt=9 → next edge bin_out=0000, gry_out=0000, wrap=0. Hold rst=1 with en=1 and load=1 → outputs stay 0.
2. Up-count wrap: load binary 1110, then en=1, up=1 for 3 cycles → bin 1111/gry 1000, then bin 0000/gry 0000 with wrap=1 for exactly that cycle, then bin 0001/gry 0001 with wrap=0.
3. Down-count wrap: load binary 0001, en=1, up=0 → bin 0000/gry 0000 with wrap=0, then bin 1111/gry 1000 with wrap=1.
4. Gray load: load=1, load_gray=1, load_val=1111 → bin_out=1010, gry_out=1111. Load binary 1100 → gry_out=1010.
5. Priority: load=1, en=1, up=1, load_val=0101 from cnt=1111 → bin_out=0101, wrap=0, no increment.
6. Sweep at WIDTH=4 and WIDTH=8: free-run 2^WIDTH+2 cycles up, then down. Check:
   - gry_out Hamming distance is 1 each step
   - gry_out == bin_out^(bin_out>>1) on every cycle
   - exactly one wrap pulse per period
